// File: rtl/xalu_md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit and the E-stage decoder.
// Optional feature macro: XALU_MADD_EN (madd/maddu/msub/msubu).
package xalu_md_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned OP_W           = 4;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd2,
    OP_MULTU = 4'd3,
    OP_DIV   = 4'd4,
    OP_DIVU  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } xalu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Ops that launch a multi-cycle operation in this build.
  function automatic logic op_valid(input logic [OP_W-1:0] op);
    logic v;
    v = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: v = 1'b1;
`ifdef XALU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: v = 1'b1;
`endif
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/xalu_md_if.sv
// E-stage <-> multiply/divide unit bus: operands, control, status and HI/LO read port.
interface xalu_md_if;
  import xalu_md_pkg::*;

  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [OP_W-1:0] XALU_OP;
  logic            HI_WE;
  logic            LO_WE;
  logic            HI_LO_sel;
  logic            cancel;
  logic            start;
  logic            busy;
  logic [XLEN-1:0] HI_LO_out;

  modport master (
    output A, B, XALU_OP, HI_WE, LO_WE, HI_LO_sel, cancel,
    input  start, busy, HI_LO_out
  );

  modport slave (
    input  A, B, XALU_OP, HI_WE, LO_WE, HI_LO_sel, cancel,
    output start, busy, HI_LO_out
  );
endinterface

// File: rtl/xalu_calc.sv
// Combinational multiply/divide datapath: {a, b, op, acc} -> {hi, lo}.
// Accumulating ops exist only when XALU_MADD_EN is defined.
module xalu_calc
  import xalu_md_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [OP_W-1:0] op,
  input  hilo_t           acc,
  output hilo_t           res
);

  logic [2*XLEN-1:0]        a_sx;
  logic [2*XLEN-1:0]        b_sx;
  logic [2*XLEN-1:0]        prod_s;
  logic [2*XLEN-1:0]        prod_u;
  logic signed [XLEN-1:0]   a_s;
  logic signed [XLEN-1:0]   b_s;
  logic                     div_zero;
  logic                     div_ovf;

  // Low 2*XLEN bits of the product of sign-extended operands equal the signed product.
  assign a_sx   = {{XLEN{a[XLEN-1]}}, a};
  assign b_sx   = {{XLEN{b[XLEN-1]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {XLEN'(0), a} * {XLEN'(0), b};

  assign a_s      = $signed(a);
  assign b_s      = $signed(b);
  assign div_zero = (b == XLEN'(0));
  assign div_ovf  = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});

`ifndef XALU_MADD_EN
  logic unused_acc;
  assign unused_acc = ^acc;
`endif

  always_comb begin
    res = '0;
    case (op)
      OP_MULT:  res = hilo_t'(prod_s);
      OP_MULTU: res = hilo_t'(prod_u);
      OP_DIV: begin
        if (div_zero) begin
          res.hi = a;
          res.lo = {XLEN{1'b1}};
        end else if (div_ovf) begin
          res.hi = XLEN'(0);
          res.lo = a;
        end else begin
          res.hi = XLEN'(a_s % b_s);
          res.lo = XLEN'(a_s / b_s);
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          res.hi = a;
          res.lo = {XLEN{1'b1}};
        end else begin
          res.hi = a % b;
          res.lo = a / b;
        end
      end
`ifdef XALU_MADD_EN
      OP_MADD:  res = hilo_t'(acc + prod_s);
      OP_MADDU: res = hilo_t'(acc + prod_u);
      OP_MSUB:  res = hilo_t'(acc - prod_s);
      OP_MSUBU: res = hilo_t'(acc - prod_u);
`endif
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/xalu_md.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Optional madd family enabled by defining XALU_MADD_EN.
module xalu_md
  import xalu_md_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  xalu_md_if.slave  bus
);

  md_state_e        state;
  md_state_e        state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  hilo_t            pend;
  hilo_t            pend_nx;
  hilo_t            hilo;
  hilo_t            hilo_nx;
  hilo_t            calc_res;
  logic             start_c;

  // Madd family accumulates onto the HI/LO value present at start.
  xalu_calc u_calc (
    .a   (bus.A),
    .b   (bus.B),
    .op  (bus.XALU_OP),
    .acc (hilo),
    .res (calc_res)
  );

  assign start_c       = op_valid(bus.XALU_OP) & ~bus.cancel & (state == ST_IDLE);
  assign bus.start     = start_c;
  assign bus.busy      = (state == ST_BUSY);
  assign bus.HI_LO_out = bus.HI_LO_sel ? hilo.lo : hilo.hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pend  <= '0;
      hilo  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pend  <= pend_nx;
      hilo  <= hilo_nx;
    end
  end

  // Start beats mthi/mtlo; cancel freezes everything except an operation already in flight.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend;
    hilo_nx  = hilo;
    case (state)
      ST_IDLE: begin
        if (start_c) begin
          state_nx = ST_BUSY;
          cnt_nx   = op_is_div(bus.XALU_OP) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          pend_nx  = calc_res;
        end else if (!bus.cancel) begin
          if (bus.HI_WE) hilo_nx.hi = bus.A;
          if (bus.LO_WE) hilo_nx.lo = bus.A;
        end
      end
      ST_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          hilo_nx  = pend;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xalu_md.sv
// Scoreboard bench for xalu_md: stimulus queues expectations, a monitor checks HI/LO and busy length.
module tb_xalu_md;
  import xalu_md_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  xalu_md_if md_if ();

  xalu_md dut (
    .clk   (clk),
    .reset (reset),
    .bus   (md_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_res;
    bit          chk_start;
    bit          start_exp;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total     = 0;
  int   bad       = 0;
  bit   snap_req  = 1'b0;
  int   busy_cnt  = 0;
  bit   prev_busy = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: owns HI_LO_sel, reads both HI and LO each cycle, pops on result or snapshot.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] hi_v;
    logic [31:0] lo_v;
    logic        b;
    logic        st;
    b  = md_if.busy;
    st = md_if.start;
    md_if.HI_LO_sel = 1'b0;
    #1 hi_v = md_if.HI_LO_out;
    md_if.HI_LO_sel = 1'b1;
    #1 lo_v = md_if.HI_LO_out;
    if (b === 1'b1) busy_cnt++;
    if (b === 1'b0 && prev_busy) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got hi=%h lo=%h want no result", hi_v, lo_v);
      end else begin
        e = sb.pop_front();
        check({e.name, ".kind"}, 32'(e.is_res), 32'd1);
        check({e.name, ".busy_cycles"}, 32'(busy_cnt), 32'(e.cyc));
        check({e.name, ".hi"}, hi_v, e.hi);
        check({e.name, ".lo"}, lo_v, e.lo);
      end
      busy_cnt = 0;
    end
    if (snap_req) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got no entry want snapshot");
      end else begin
        e = sb.pop_front();
        check({e.name, ".kind"}, 32'(e.is_res), 32'd0);
        check({e.name, ".busy"}, 32'(b), 32'd0);
        if (e.chk_start) check({e.name, ".start"}, 32'(st), 32'(e.start_exp));
        check({e.name, ".hi"}, hi_v, e.hi);
        check({e.name, ".lo"}, lo_v, e.lo);
      end
    end
    prev_busy = (b === 1'b1);
  end

  // The hazard unit must never issue into a busy unit.
  always @(negedge clk) begin
    if (!reset && md_if.busy === 1'b1)
      assert (!(op_valid(md_if.XALU_OP) || md_if.HI_WE || md_if.LO_WE))
        else $error("stall rule broken: issue while busy");
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic hwe, input logic lwe, input logic can);
    @(posedge clk);
    #1;
    snap_req      = 1'b0;
    md_if.XALU_OP = op;
    md_if.A       = a;
    md_if.B       = b;
    md_if.HI_WE   = hwe;
    md_if.LO_WE   = lwe;
    md_if.cancel  = can;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic snap(input string nm, input logic [31:0] hi, input logic [31:0] lo,
                      input bit cs, input bit se);
    exp_t e;
    e.name = nm; e.is_res = 1'b0; e.chk_start = cs; e.start_exp = se;
    e.hi = hi; e.lo = lo; e.cyc = 0;
    sb.push_back(e);
    snap_req = 1'b1;
  endtask

  task automatic expect_res(input string nm, input logic [31:0] hi, input logic [31:0] lo,
                            input int cyc);
    exp_t e;
    e.name = nm; e.is_res = 1'b1; e.chk_start = 1'b0; e.start_exp = 1'b0;
    e.hi = hi; e.lo = lo; e.cyc = cyc;
    sb.push_back(e);
  endtask

  initial begin
    md_if.A = '0; md_if.B = '0; md_if.XALU_OP = '0;
    md_if.HI_WE = 1'b0; md_if.LO_WE = 1'b0; md_if.cancel = 1'b0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    snap("reset", 32'h0, 32'h0, 1'b1, 1'b0);

    drive(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
    snap("mult_issue", 32'h0, 32'h0, 1'b1, 1'b1);
    expect_res("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    idle(7);

    drive(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    snap("multu_issue", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b1);
    expect_res("multu", 32'hFFFF_FFFE, 32'h0000_0001, 5);
    idle(7);

    drive(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    expect_res("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    idle(12);

    drive(4'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
    expect_res("divu_zero", 32'd7, 32'hFFFF_FFFF, 10);
    idle(12);

    drive(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    expect_res("div_ovf", 32'h0, 32'h8000_0000, 10);
    idle(12);

    drive(4'd4, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    expect_res("div_negdivisor", 32'd1, 32'hFFFF_FFFD, 10);
    idle(12);

    drive(4'd0, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(1);
    snap("mthi", 32'h1234_5678, 32'hFFFF_FFFD, 1'b0, 1'b0);

    drive(4'd0, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b1, 1'b0);
    idle(1);
    snap("mthi_mtlo", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0);

    drive(4'd2, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1);
    snap("cancel_start", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b0);
    idle(1);
    snap("cancel_after", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0);
    idle(6);

    drive(4'd0, 32'h1111_1111, 32'd0, 1'b1, 1'b1, 1'b1);
    idle(1);
    snap("cancel_mtx", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0);

    drive(4'd15, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
    snap("bad_op", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b0);
    idle(6);
    snap("bad_op_after", 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0);

    drive(4'd0, 32'h0, 32'd0, 1'b1, 1'b0, 1'b0);
    drive(4'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0);
    idle(1);
    snap("madd_setup", 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    drive(4'd7, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
`ifdef XALU_MADD_EN
    snap("maddu_issue", 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    expect_res("maddu", 32'd1, 32'd0, 5);
    idle(7);
    drive(4'd8, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    expect_res("msub", 32'h0, 32'hFFFF_FFFA, 5);
    idle(7);
`else
    snap("maddu_off", 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    idle(6);
    snap("maddu_off_after", 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
`endif

    drive(4'd2, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    expect_res("rst_abort", 32'h0, 32'h0, 3);
    idle(2);
    @(posedge clk);
    #1;
    snap_req = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
    snap("post_reset", 32'h0, 32'h0, 1'b1, 1'b0);
    idle(2);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
